// File: rtl/bf8b_pkg.sv
// Shared definitions for the bf8b core: opcode bytes, execute-stage state
// encoding and the data-memory read latency.
package bf8b_pkg;

  localparam logic [7:0] OP_INC   = 8'h2B;
  localparam logic [7:0] OP_DEC   = 8'h2D;
  localparam logic [7:0] OP_LEFT  = 8'h3C;
  localparam logic [7:0] OP_RIGHT = 8'h3E;
  localparam logic [7:0] OP_OUT   = 8'h2E;
  localparam logic [7:0] OP_IN    = 8'h2C;
  localparam logic [7:0] OP_LOOP  = 8'h5B;
  localparam logic [7:0] OP_END   = 8'h5D;

  localparam int MEM_LATENCY = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DECODE,
    ST_RD_WAIT,
    ST_RD_SAMPLE,
    ST_WRITE,
    ST_OUT_HS,
    ST_IN_HS,
    ST_SCAN_ADDR,
    ST_SCAN_WAIT,
    ST_SCAN_CHECK,
    ST_DONE
  } exec_state_t;

endpackage

// File: rtl/bracket_scanner.sv
// Walks program memory from a bracket looking for its partner; the execute
// FSM paces it with step (advance address) and check (consume sampled byte).
module bracket_scanner #(
  parameter int SCAN_LIMIT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_fwd,
  input  logic [7:0] i_start_addr,
  input  logic       i_step,
  input  logic       i_check,
  input  logic [7:0] i_prog_data,
  output logic [7:0] o_prog_addr,
  output logic       o_done,
  output logic       o_matched,
  output logic [7:0] o_match_addr
);
  import bf8b_pkg::*;

  logic [7:0] r_addr;
  logic [8:0] r_depth;
  logic [8:0] r_steps;
  logic       r_fwd;
  logic       w_same;
  logic       w_opp;
  logic [8:0] w_depth_next;

  assign w_same = (i_prog_data == (r_fwd ? OP_LOOP : OP_END));
  assign w_opp  = (i_prog_data == (r_fwd ? OP_END : OP_LOOP));

  always_comb begin
    w_depth_next = r_depth;
    if (w_same)
      w_depth_next = r_depth + 9'd1;
    else if (w_opp)
      w_depth_next = r_depth - 9'd1;
  end

  // Results are combinational so the FSM can leave SCAN_CHECK on the same edge.
  assign o_matched    = i_check && (w_depth_next == 9'd0);
  assign o_done       = o_matched || (i_check && ((r_steps + 9'd1) == 9'(SCAN_LIMIT)));
  assign o_match_addr = r_addr;
  assign o_prog_addr  = r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= 8'd0;
      r_depth <= 9'd0;
      r_steps <= 9'd0;
      r_fwd   <= 1'b0;
    end else if (i_start) begin
      r_addr  <= i_start_addr;
      r_depth <= 9'd1;
      r_steps <= 9'd0;
      r_fwd   <= i_fwd;
    end else if (i_step) begin
      r_addr <= r_fwd ? r_addr + 8'd1 : r_addr - 8'd1;
    end else if (i_check) begin
      r_depth <= w_depth_next;
      r_steps <= r_steps + 9'd1;
    end
  end

endmodule

// File: rtl/bf_execute.sv
// Execute stage of the bf8b core: runs one Brainfuck instruction per en
// handshake, with all outputs driven from registers.
module bf_execute #(
  parameter int SCAN_LIMIT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] inst_in,
  input  logic [7:0] pc_in,
  output logic [7:0] pc_next,
  output logic       ready,
  output logic       err,
  output logic [7:0] dp,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic [7:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready
);
  import bf8b_pkg::*;

  localparam logic [1:0] RD_WAIT_LAST = 2'(MEM_LATENCY - 2);

  exec_state_t r_state, w_state;
  logic       r_en_d;
  logic [7:0] r_inst, w_inst;
  logic [7:0] r_pc, w_pc;
  logic [7:0] r_dp, w_dp;
  logic [7:0] r_pc_next, w_pc_next;
  logic [7:0] r_mem_addr, w_mem_addr;
  logic [7:0] r_mem_wdata, w_mem_wdata;
  logic       r_mem_we, w_mem_we;
  logic [7:0] r_out_data, w_out_data;
  logic       r_out_valid, w_out_valid;
  logic       r_in_ready, w_in_ready;
  logic       r_ready, w_ready;
  logic       r_err, w_err;
  logic [7:0] r_cell, w_cell;
  logic [1:0] r_wait, w_wait;
  logic       w_scan_start, w_scan_step, w_scan_check;
  logic       w_scan_done, w_scan_matched;
  logic [7:0] w_match_addr;

  bracket_scanner #(.SCAN_LIMIT(SCAN_LIMIT)) u_scanner (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (w_scan_start),
    .i_fwd        (r_inst == OP_LOOP),
    .i_start_addr (r_pc),
    .i_step       (w_scan_step),
    .i_check      (w_scan_check),
    .i_prog_data  (prog_data),
    .o_prog_addr  (prog_addr),
    .o_done       (w_scan_done),
    .o_matched    (w_scan_matched),
    .o_match_addr (w_match_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_en_d      <= 1'b0;
      r_inst      <= 8'd0;
      r_pc        <= 8'd0;
      r_dp        <= 8'd0;
      r_pc_next   <= 8'd0;
      r_mem_addr  <= 8'd0;
      r_mem_wdata <= 8'd0;
      r_mem_we    <= 1'b0;
      r_out_data  <= 8'd0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_cell      <= 8'd0;
      r_wait      <= 2'd0;
    end else begin
      r_state     <= w_state;
      r_en_d      <= en;
      r_inst      <= w_inst;
      r_pc        <= w_pc;
      r_dp        <= w_dp;
      r_pc_next   <= w_pc_next;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_mem_we    <= w_mem_we;
      r_out_data  <= w_out_data;
      r_out_valid <= w_out_valid;
      r_in_ready  <= w_in_ready;
      r_ready     <= w_ready;
      r_err       <= w_err;
      r_cell      <= w_cell;
      r_wait      <= w_wait;
    end
  end

  // Dropping en in any busy state abandons the instruction; pulses and
  // handshake requests are simply not re-asserted.
  always_comb begin
    w_state      = r_state;
    w_inst       = r_inst;
    w_pc         = r_pc;
    w_dp         = r_dp;
    w_pc_next    = r_pc_next;
    w_mem_addr   = r_mem_addr;
    w_mem_wdata  = r_mem_wdata;
    w_mem_we     = 1'b0;
    w_out_data   = r_out_data;
    w_out_valid  = r_out_valid;
    w_in_ready   = r_in_ready;
    w_ready      = 1'b0;
    w_err        = r_err;
    w_cell       = r_cell;
    w_wait       = r_wait;
    w_scan_start = 1'b0;
    w_scan_step  = 1'b0;
    w_scan_check = 1'b0;
    if (r_state != ST_IDLE && !en) begin
      w_state     = ST_IDLE;
      w_out_valid = 1'b0;
      w_in_ready  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en && !r_en_d) begin
            w_state = ST_DECODE;
            w_inst  = inst_in;
            w_pc    = pc_in;
          end
        end
        ST_DECODE: begin
          w_pc_next = r_pc + 8'd1;
          case (r_inst)
            OP_RIGHT: begin
              w_dp    = r_dp + 8'd1;
              w_state = ST_DONE;
            end
            OP_LEFT: begin
              w_dp    = r_dp - 8'd1;
              w_state = ST_DONE;
            end
            OP_INC, OP_DEC, OP_OUT, OP_IN, OP_LOOP, OP_END: begin
              w_mem_addr = r_dp;
              w_wait     = 2'd0;
              w_state    = ST_RD_WAIT;
            end
            default: w_state = ST_DONE;
          endcase
        end
        ST_RD_WAIT: begin
          if (r_wait == RD_WAIT_LAST)
            w_state = ST_RD_SAMPLE;
          else
            w_wait = r_wait + 2'd1;
        end
        ST_RD_SAMPLE: begin
          w_cell = mem_rdata;
          case (r_inst)
            OP_INC, OP_DEC: w_state = ST_WRITE;
            OP_OUT: begin
              w_out_data  = mem_rdata;
              w_out_valid = 1'b1;
              w_state     = ST_OUT_HS;
            end
            OP_IN: begin
              w_in_ready = 1'b1;
              w_state    = ST_IN_HS;
            end
            OP_LOOP, OP_END: begin
              if ((r_inst == OP_LOOP) == (mem_rdata == 8'd0)) begin
                w_scan_start = 1'b1;
                w_state      = ST_SCAN_ADDR;
              end else begin
                w_state = ST_DONE;
              end
            end
            default: w_state = ST_DONE;
          endcase
        end
        ST_WRITE: begin
          w_mem_we    = 1'b1;
          w_mem_wdata = (r_inst == OP_INC) ? r_cell + 8'd1 : r_cell - 8'd1;
          w_state     = ST_DONE;
        end
        ST_OUT_HS: begin
          if (out_ready) begin
            w_out_valid = 1'b0;
            w_state     = ST_DONE;
          end
        end
        ST_IN_HS: begin
          if (in_valid) begin
            w_in_ready  = 1'b0;
            w_mem_we    = 1'b1;
            w_mem_wdata = in_data;
            w_state     = ST_DONE;
          end
        end
        ST_SCAN_ADDR: begin
          w_scan_step = 1'b1;
          w_state     = ST_SCAN_WAIT;
        end
        ST_SCAN_WAIT: w_state = ST_SCAN_CHECK;
        ST_SCAN_CHECK: begin
          w_scan_check = 1'b1;
          if (w_scan_done) begin
            if (w_scan_matched)
              w_pc_next = w_match_addr + 8'd1;
            else
              w_err = 1'b1;
            w_state = ST_DONE;
          end else begin
            w_state = ST_SCAN_ADDR;
          end
        end
        ST_DONE: w_ready = 1'b1;
        default: w_state = ST_IDLE;
      endcase
    end
  end

  assign pc_next   = r_pc_next;
  assign ready     = r_ready;
  assign err       = r_err;
  assign dp        = r_dp;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;

endmodule
